uart_mmio: RTL

Memory-mapped 8N1 UART peripheral that consumes the core's data-side bus. The core's address decoder drives this block with the UART block-select, write enable, ALU-computed address and register write data. The block returns read data to the core's memory read-data mux.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_mmio_if.sv | 13 +
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_mmio.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_mmio peripheral: register word offsets
// (decoded from addr[4:2]), STATUS bit positions and the common FSM state type.
package uart_pkg;

    localparam logic [2:0] UART_TXDATA  = 3'd0;
    localparam logic [2:0] UART_RXDATA  = 3'd1;
    localparam logic [2:0] UART_STATUS  = 3'd2;
    localparam logic [2:0] UART_BAUDDIV = 3'd3;
    localparam logic [2:0] UART_CTRL    = 3'd4;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_IDLE    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_TX_BUSY    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// Data-side bus between the core's address decoder and the UART block.
// The core is the master; the UART returns combinational read data.
interface uart_mmio_if;
    logic        en;
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output en, output we, output re, output addr, output wd, input rd);
    modport slave  (input en, input we, input re, input addr, input wd, output rd);
endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO for the transmit path. DEPTH must be a power of two
// so the pointers wrap naturally. A push into a full FIFO is dropped unless
// a pop happens on the same edge, in which case the push is accepted.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed since empty/full gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART. TX: FIFO feeding a shift FSM. RX: 2-flop
// synchroniser, mid-bit sampling FSM and a one-byte holding register.
// Optional feature macro UART_LOOPBACK_EN adds the CTRL register (offset
// 0x10) whose bit0 routes internal tx into the receiver and parks the pin high.
module uart_mmio
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_DEFAULT = 16'd434,
    parameter int          TX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_mmio_if.slave  bus,
    output logic        tx,
    input  logic        rx
);
    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rx_pop_now;
    logic        status_w1c;
    logic [15:0] baud_div;

    assign reg_sel    = bus.addr[4:2];
    assign wr_en      = bus.en && bus.we;
    assign rx_pop_now = bus.en && bus.re && (reg_sel == UART_RXDATA);
    assign status_w1c = wr_en && (reg_sel == UART_STATUS);

    // ---------------- TX path ----------------
    uart_state_t tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit_idx;
    logic [7:0]  tx_shift;
    logic        tx_bit_done;
    logic        tx_pop;
    logic        tx_int;
    logic        tx_busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en && (reg_sel == UART_TXDATA)),
        .pop   (tx_pop),
        .din   (bus.wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_bit_done = (tx_cnt >= baud_div - 16'd1);
    assign tx_busy     = (tx_state != IDLE);

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    // TX next-state: frames chain directly from STOP into START when data waits.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:    if (!fifo_empty) tx_next = START;
            START:   if (tx_bit_done) tx_next = DATA;
            DATA:    if (tx_bit_done && tx_bit_idx == 3'd7) tx_next = STOP;
            STOP:    if (tx_bit_done) tx_next = fifo_empty ? IDLE : START;
            default: tx_next = IDLE;
        endcase
    end

    // TX outputs: line level and the FIFO pop that starts each frame.
    always_comb begin
        tx_int = 1'b1;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE:    tx_pop = !fifo_empty;
            START:   tx_int = 1'b0;
            DATA:    tx_int = tx_shift[0];
            STOP:    tx_pop = tx_bit_done && !fifo_empty;
            default: tx_int = 1'b1;
        endcase
    end

    // TX bit timer and shift register; a pop loads the next byte and restarts timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
        end else if (tx_pop) begin
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= fifo_dout;
        end else if (tx_state == IDLE) begin
            tx_cnt <= '0;
        end else if (tx_bit_done) begin
            tx_cnt <= '0;
            if (tx_state == DATA) begin
                tx_shift   <= {1'b0, tx_shift[7:1]};
                tx_bit_idx <= tx_bit_idx + 3'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end

    // ---------------- Loopback / pin muxing ----------------
    logic rx_in;
`ifdef UART_LOOPBACK_EN
    logic loopback;

    // CTRL register holding the loopback enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                loopback <= 1'b0;
        else if (wr_en && reg_sel == UART_CTRL)    loopback <= bus.wd[0];
    end

    assign rx_in = loopback ? tx_int : rx;
    assign tx    = loopback ? 1'b1   : tx_int;
`else
    assign rx_in = rx;
    assign tx    = tx_int;
`endif

    // ---------------- RX path ----------------
    uart_state_t rx_state, rx_next;
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit_idx;
    logic [7:0]  rx_shift;
    logic        rx_bit_done;
    logic        rx_half_done;
    logic        rx_sample;
    logic        rx_stop_ok;
    logic        rx_stop_bad;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_overrun;
    logic        frame_err;

    assign rx_s         = rx_sync[1];
    assign rx_bit_done  = (rx_cnt >= baud_div - 16'd1);
    assign rx_half_done = (rx_cnt >= {1'b0, baud_div[15:1]} - 16'd1);

    // Two-flop synchroniser, idling at the line's mark level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx_in};
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    // RX next-state: half-bit start check rejects short glitches.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    if (!rx_s) rx_next = START;
            START:   if (rx_half_done) rx_next = rx_s ? IDLE : DATA;
            DATA:    if (rx_bit_done && rx_bit_idx == 3'd7) rx_next = STOP;
            STOP:    if (rx_bit_done) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // RX outputs: sampling strobe and stop-bit outcome strobes.
    always_comb begin
        rx_sample   = 1'b0;
        rx_stop_ok  = 1'b0;
        rx_stop_bad = 1'b0;
        case (rx_state)
            DATA:    rx_sample = rx_bit_done;
            STOP: begin
                rx_stop_ok  = rx_bit_done && rx_s;
                rx_stop_bad = rx_bit_done && !rx_s;
            end
            default: rx_sample = 1'b0;
        endcase
    end

    // RX bit timer and LSB-first deserialiser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
        end else begin
            if (rx_state == IDLE || rx_next != rx_state || rx_sample) rx_cnt <= '0;
            else                                                    rx_cnt <= rx_cnt + 16'd1;
            if (rx_state == START) rx_bit_idx <= '0;
            if (rx_sample) begin
                rx_shift   <= {rx_s, rx_shift[7:1]};
                rx_bit_idx <= rx_bit_idx + 3'd1;
            end
        end
    end

    // Holding register: a pop coinciding with a new byte lets the byte in cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else if (rx_stop_ok && (!rx_valid || rx_pop_now)) begin
            rx_valid <= 1'b1;
            rx_byte  <= rx_shift;
        end else if (rx_pop_now) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error event wins over a same-cycle W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rx_stop_ok && rx_valid && !rx_pop_now)  rx_overrun <= 1'b1;
            else if (status_w1c && bus.wd[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
            if (rx_stop_bad)                             frame_err <= 1'b1;
            else if (status_w1c && bus.wd[ST_FRAME_ERR]) frame_err <= 1'b0;
        end
    end

    // Baud divisor; values below 2 would break the half-bit start check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   baud_div <= DIV_DEFAULT;
        else if (wr_en && reg_sel == UART_BAUDDIV)    baud_div <= (bus.wd[15:0] < 16'd2) ? 16'd2 : bus.wd[15:0];
    end

    // Combinational read mux back to the core.
    always_comb begin
        bus.rd = '0;
        if (bus.en) begin
            case (reg_sel)
                UART_RXDATA:  bus.rd = {rx_valid, 23'b0, rx_byte};
                UART_STATUS: begin
                    bus.rd[ST_TX_FULL]    = fifo_full;
                    bus.rd[ST_TX_IDLE]    = fifo_empty && (tx_state == IDLE);
                    bus.rd[ST_RX_VALID]   = rx_valid;
                    bus.rd[ST_RX_OVERRUN] = rx_overrun;
                    bus.rd[ST_FRAME_ERR]  = frame_err;
                    bus.rd[ST_TX_BUSY]    = tx_busy;
                end
                UART_BAUDDIV: bus.rd = {16'b0, baud_div};
`ifdef UART_LOOPBACK_EN
                UART_CTRL:    bus.rd = {31'b0, loopback};
`endif
                default:      bus.rd = '0;
            endcase
        end
    end
endmodule
